// File: rtl/ic_req_queue.sv
// In-order fetch request queue between the PC stage and the ICache stage.
// Empty queue with a downstream go bypasses straight into the output register.
module ic_req_queue #(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 4,
  parameter int STALL_W = 6,
  parameter int STAGE   = 2,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  pc_pc,
  input  logic               pc_ce,
  output logic [ADDR_W-1:0]  icache_pc,
  output logic               icache_ce,
  output logic               buf_full,
  output logic [CNT_W-1:0]   buf_count,
  output logic               overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic up_go;
  logic dn_go;
  logic push_req;
  logic empty;
  logic full;
  logic pop;
  logic bypass;
  logic push;
  logic drop;

  assign up_go    = ~stall[STAGE-1];
  assign dn_go    = ~stall[STAGE];
  assign push_req = up_go & pc_ce;
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));

  // NOTE: every variable gets a default before the conditional logic so no latch is inferred.
  always_comb begin
    pop    = 1'b0;
    bypass = 1'b0;
    push   = 1'b0;
    drop   = 1'b0;
    if (dn_go && !empty) begin
      pop = 1'b1;
    end
    if (dn_go && empty && push_req) begin
      bypass = 1'b1;
    end
    if (push_req && !bypass) begin
      // A pop in the same cycle frees the slot the push would need.
      if (!full || pop) begin
        push = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      icache_pc <= '0;
      icache_ce <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
    end else if (flush) begin
      icache_pc <= '0;
      icache_ce <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (pop) begin
        icache_pc <= mem[rd_ptr];
        icache_ce <= 1'b1;
        rd_ptr    <= rd_ptr + 1'b1;
      end else if (bypass) begin
        icache_pc <= pc_pc;
        icache_ce <= 1'b1;
      end else if (dn_go) begin
        icache_pc <= '0;
        icache_ce <= 1'b0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // NOTE: the storage array has no reset; occupancy and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem[wr_ptr] <= pc_pc;
    end
  end

  assign buf_count = count;
  assign buf_full  = full;

  count_in_range: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_ic_req_queue.sv
// Bench for ic_req_queue: hand-computed vector table for the directed scenarios,
// then randomized traffic compared against a queue-based reference model.
module tb_ic_req_queue;

  localparam int ADDR_W  = 32;
  localparam int DEPTH   = 4;
  localparam int STALL_W = 6;
  localparam int STAGE   = 2;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  localparam logic [STALL_W-1:0] S_NO = '0;
  localparam logic [STALL_W-1:0] S_DN = STALL_W'(1) << STAGE;
  localparam logic [STALL_W-1:0] S_UP = STALL_W'(1) << (STAGE - 1);

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [ADDR_W-1:0]  pc_pc;
  logic               pc_ce;
  logic [ADDR_W-1:0]  icache_pc;
  logic               icache_ce;
  logic               buf_full;
  logic [CNT_W-1:0]   buf_count;
  logic               overflow;

  int tests_run = 0;
  int tests_failed = 0;

  ic_req_queue #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STALL_W(STALL_W), .STAGE(STAGE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .pc_pc(pc_pc), .pc_ce(pc_ce),
    .icache_pc(icache_pc), .icache_ce(icache_ce),
    .buf_full(buf_full), .buf_count(buf_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               rst;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               ce;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  epc;
    logic               ece;
    int                 ecnt;
    logic               efull;
    logic               eovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [STALL_W-1:0] s, logic f, logic c,
                              logic [ADDR_W-1:0] p, logic [ADDR_W-1:0] epc, logic ece,
                              int ecnt, logic efull, logic eovf);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.ce = c; v.pc = p;
    v.epc = epc; v.ece = ece; v.ecnt = ecnt; v.efull = efull; v.eovf = eovf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply(input logic r, input logic [STALL_W-1:0] s, input logic f,
                       input logic c, input logic [ADDR_W-1:0] p);
    rst = r; stall = s; flush = f; pc_ce = c; pc_pc = p;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a plain FIFO of addresses plus the output register contents.
  logic [ADDR_W-1:0] mq[$];
  logic [ADDR_W-1:0] m_pc;
  logic              m_ce;
  logic              m_ovf;

  task automatic model_step(input logic r, input logic [STALL_W-1:0] s, input logic f,
                            input logic c, input logic [ADDR_W-1:0] p);
    bit want_push;
    if (r) begin
      mq.delete(); m_pc = '0; m_ce = 1'b0; m_ovf = 1'b0;
    end else if (f) begin
      mq.delete(); m_pc = '0; m_ce = 1'b0;
    end else begin
      want_push = !s[STAGE-1] && c;
      if (!s[STAGE]) begin
        if (mq.size() > 0) begin
          m_pc = mq.pop_front(); m_ce = 1'b1;
        end else if (want_push) begin
          m_pc = p; m_ce = 1'b1; want_push = 0;
        end else begin
          m_pc = '0; m_ce = 1'b0;
        end
      end
      if (want_push) begin
        if (mq.size() < DEPTH) mq.push_back(p);
        else m_ovf = 1'b1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = S_NO; flush = 1'b0; pc_ce = 1'b0; pc_pc = '0;

    // Reset, then bypass
    vecs.push_back(mk(1, S_NO, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0));
    vecs.push_back(mk(1, S_NO, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0));
    vecs.push_back(mk(0, S_NO, 0, 1, 32'hBFC00000, 32'hBFC00000, 1, 0, 0, 0));
    vecs.push_back(mk(0, S_NO, 0, 1, 32'hBFC00004, 32'hBFC00004, 1, 0, 0, 0));
    // Downstream stall fill, then drain and bubble
    vecs.push_back(mk(0, S_DN, 0, 1, 32'h100,      32'hBFC00004, 1, 1, 0, 0));
    vecs.push_back(mk(0, S_DN, 0, 1, 32'h104,      32'hBFC00004, 1, 2, 0, 0));
    vecs.push_back(mk(0, S_DN, 0, 1, 32'h108,      32'hBFC00004, 1, 3, 0, 0));
    vecs.push_back(mk(0, S_NO, 0, 0, 32'h0,        32'h100,      1, 2, 0, 0));
    vecs.push_back(mk(0, S_NO, 0, 0, 32'h0,        32'h104,      1, 1, 0, 0));
    vecs.push_back(mk(0, S_NO, 0, 0, 32'h0,        32'h108,      1, 0, 0, 0));
    vecs.push_back(mk(0, S_NO, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0));
    // Fill past full: fifth push dropped, overflow sticks
    vecs.push_back(mk(0, S_DN, 0, 1, 32'h300,      32'h0,        0, 1, 0, 0));
    vecs.push_back(mk(0, S_DN, 0, 1, 32'h304,      32'h0,        0, 2, 0, 0));
    vecs.push_back(mk(0, S_DN, 0, 1, 32'h308,      32'h0,        0, 3, 0, 0));
    vecs.push_back(mk(0, S_DN, 0, 1, 32'h30C,      32'h0,        0, 4, 1, 0));
    vecs.push_back(mk(0, S_DN, 0, 1, 32'h310,      32'h0,        0, 4, 1, 1));
    vecs.push_back(mk(0, S_NO, 0, 0, 32'h0,        32'h300,      1, 3, 0, 1));
    vecs.push_back(mk(0, S_NO, 0, 0, 32'h0,        32'h304,      1, 2, 0, 1));
    vecs.push_back(mk(0, S_NO, 0, 0, 32'h0,        32'h308,      1, 1, 0, 1));
    vecs.push_back(mk(0, S_NO, 0, 0, 32'h0,        32'h30C,      1, 0, 0, 1));
    vecs.push_back(mk(0, S_NO, 0, 0, 32'h0,        32'h0,        0, 0, 0, 1));
    // Simultaneous push and pop keep the count steady
    vecs.push_back(mk(0, S_DN, 0, 1, 32'h200,      32'h0,        0, 1, 0, 1));
    vecs.push_back(mk(0, S_DN, 0, 1, 32'h204,      32'h0,        0, 2, 0, 1));
    vecs.push_back(mk(0, S_NO, 0, 1, 32'h208,      32'h200,      1, 2, 0, 1));
    vecs.push_back(mk(0, S_NO, 0, 1, 32'h20C,      32'h204,      1, 2, 0, 1));
    vecs.push_back(mk(0, S_NO, 0, 1, 32'h210,      32'h208,      1, 2, 0, 1));
    vecs.push_back(mk(0, S_NO, 0, 0, 32'h0,        32'h20C,      1, 1, 0, 1));
    vecs.push_back(mk(0, S_NO, 0, 0, 32'h0,        32'h210,      1, 0, 0, 1));
    // Flush mid-drain with a concurrent push
    vecs.push_back(mk(0, S_DN, 0, 1, 32'h400,      32'h210,      1, 1, 0, 1));
    vecs.push_back(mk(0, S_DN, 0, 1, 32'h404,      32'h210,      1, 2, 0, 1));
    vecs.push_back(mk(0, S_DN, 0, 1, 32'h408,      32'h210,      1, 3, 0, 1));
    vecs.push_back(mk(0, S_NO, 0, 0, 32'h0,        32'h400,      1, 2, 0, 1));
    vecs.push_back(mk(0, S_NO, 1, 1, 32'h500,      32'h0,        0, 0, 0, 1));
    vecs.push_back(mk(0, S_NO, 0, 0, 32'h0,        32'h0,        0, 0, 0, 1));
    // Upstream-only stall inserts bubbles
    vecs.push_back(mk(0, S_UP, 0, 1, 32'h600,      32'h0,        0, 0, 0, 1));
    vecs.push_back(mk(0, S_UP, 0, 1, 32'h604,      32'h0,        0, 0, 0, 1));
    vecs.push_back(mk(0, S_NO, 0, 1, 32'h608,      32'h608,      1, 0, 0, 1));
    vecs.push_back(mk(0, S_UP, 0, 1, 32'h60C,      32'h0,        0, 0, 0, 1));
    // Push accepted while full because a pop frees a slot
    vecs.push_back(mk(0, S_DN, 0, 1, 32'h700,      32'h0,        0, 1, 0, 1));
    vecs.push_back(mk(0, S_DN, 0, 1, 32'h704,      32'h0,        0, 2, 0, 1));
    vecs.push_back(mk(0, S_DN, 0, 1, 32'h708,      32'h0,        0, 3, 0, 1));
    vecs.push_back(mk(0, S_DN, 0, 1, 32'h70C,      32'h0,        0, 4, 1, 1));
    vecs.push_back(mk(0, S_NO, 0, 1, 32'h710,      32'h700,      1, 4, 1, 1));
    vecs.push_back(mk(0, S_NO, 0, 0, 32'h0,        32'h704,      1, 3, 0, 1));
    vecs.push_back(mk(0, S_NO, 0, 0, 32'h0,        32'h708,      1, 2, 0, 1));
    vecs.push_back(mk(0, S_NO, 0, 0, 32'h0,        32'h70C,      1, 1, 0, 1));
    vecs.push_back(mk(0, S_NO, 0, 0, 32'h0,        32'h710,      1, 0, 0, 1));
    vecs.push_back(mk(0, S_NO, 0, 0, 32'h0,        32'h0,        0, 0, 0, 1));
    // Both stalls: nothing moves; then reset clears overflow
    vecs.push_back(mk(0, S_UP | S_DN, 0, 1, 32'h800, 32'h0,      0, 0, 0, 1));
    vecs.push_back(mk(1, S_NO, 0, 1, 32'h900,      32'h0,        0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].ce, vecs[i].pc);
      check($sformatf("vec%0d.icache_pc", i), icache_pc, vecs[i].epc);
      check($sformatf("vec%0d.icache_ce", i), 32'(icache_ce), 32'(vecs[i].ece));
      check($sformatf("vec%0d.buf_count", i), 32'(buf_count), 32'(vecs[i].ecnt));
      check($sformatf("vec%0d.buf_full", i), 32'(buf_full), 32'(vecs[i].efull));
      check($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(vecs[i].eovf));
    end

    // Randomized traffic against the reference model
    model_step(1, S_NO, 0, 0, '0);
    apply(1, S_NO, 0, 0, '0);
    for (int n = 0; n < 3000; n++) begin
      logic               r, f, c;
      logic [STALL_W-1:0] s;
      logic [ADDR_W-1:0]  p;
      r = ($urandom_range(0, 299) == 0);
      f = ($urandom_range(0, 39) == 0);
      c = ($urandom_range(0, 3) != 0);
      s = STALL_W'($urandom);
      s[STAGE]   = ($urandom_range(0, 9) < 4);
      s[STAGE-1] = ($urandom_range(0, 9) < 2);
      p = {$urandom} & 32'hFFFF_FFFC;
      model_step(r, s, f, c, p);
      apply(r, s, f, c, p);
      check($sformatf("rnd%0d.icache_pc", n), icache_pc, m_pc);
      check($sformatf("rnd%0d.icache_ce", n), 32'(icache_ce), 32'(m_ce));
      check($sformatf("rnd%0d.buf_count", n), 32'(buf_count), 32'(mq.size()));
      check($sformatf("rnd%0d.buf_full", n), 32'(buf_full), 32'(mq.size() == DEPTH));
      check($sformatf("rnd%0d.overflow", n), 32'(overflow), 32'(m_ovf));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
